// File: rtl/token_ring_arbiter.sv
// Token-ring arbiter: one-hot rotating priority pointer, single-grant tenure.
// A grant is issued one cycle after req is sampled in IDLE. It is held while the
// owner keeps req high. Each release leaves exactly one grant-free cycle.
// Optional tenure preemption is compiled in with `define ARB_TIMEOUT_EN.
module token_ring_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N-1:0]               req,
    output logic [N-1:0]               grant,
    output logic                       grant_valid,
    output logic [N-1:0]               token,
    output logic [$clog2(MAX_HOLD):0]  hold_cnt
);

    localparam int unsigned HW = $clog2(MAX_HOLD) + 1;
    localparam logic [N-1:0] OneLsb = N'(1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e       state_q;
    logic [N-1:0] grant_q;
    logic [N-1:0] token_q;

    logic [N-1:0] req_hi;
    logic [N-1:0] pick;
    logic [N-1:0] sel;
    logic [N-1:0] sel_rot;
    logic         release_w;

`ifdef ARB_TIMEOUT_EN
    localparam logic [HW-1:0] HoldMax  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);
    logic [HW-1:0] hold_q;
`endif

    // Priority pick: lowest set req at or above the token, else lowest set req (wrap).
    always_comb begin
        req_hi    = req & ~(token_q - OneLsb);
        pick      = (req_hi != '0) ? req_hi : req;
        sel       = pick & (~pick + OneLsb);
        sel_rot   = {sel[N-2:0], sel[N-1]};
        release_w = ((req & grant_q) == '0);
`ifdef ARB_TIMEOUT_EN
        // Preempt only when someone else is waiting at the end of the tenure.
        if ((hold_q == HoldLast) && ((req & ~grant_q) != '0)) begin
            release_w = 1'b1;
        end
`endif
    end

    // Arbitration FSM with registered grant, token and tenure counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            token_q <= OneLsb;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req != '0) begin
                        state_q <= StBusy;
                        grant_q <= sel;
                        token_q <= sel_rot;
`ifdef ARB_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                StBusy: begin
                    if (release_w) begin
                        state_q <= StIdle;
                        grant_q <= '0;
`ifdef ARB_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        if (hold_q != HoldMax) begin
                            hold_q <= hold_q + HW'(1);
                        end
`endif
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign token       = token_q;
`ifdef ARB_TIMEOUT_EN
    assign hold_cnt    = hold_q;
`else
    assign hold_cnt    = '0;
`endif

endmodule

// File: doc/token_ring_arbiter.md
TOKEN_RING_ARBITER -- requirements
Module: token_ring_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (N >= 2).
REQ-002 SHALL have parameter MAX_HOLD, default 8, maximum grant tenure in cycles when ARB_TIMEOUT_EN is defined (MAX_HOLD >= 2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req  input  N  per-requester request level.
REQ-006 SHALL have port grant  output  N  registered one-hot grant, or all-zero.
REQ-007 SHALL have port grant_valid  output  1  equals OR of grant.
REQ-008 SHALL have port token  output  N  registered one-hot priority pointer (ring counter).
REQ-009 SHALL have port hold_cnt  output  $clog2(MAX_HOLD)+1  cycles the current grant has been held.

Function
REQ-010 SHALL implement two states, IDLE and BUSY; grant is all-zero in IDLE and one-hot in BUSY.
REQ-011 In IDLE with req != 0, SHALL select the first set req bit scanning from the token position upward with wrap-around (bit N-1 wraps to bit 0).
REQ-012 SHALL assert grant for the selected requester on the next rising edge, so grant appears one cycle after req is sampled, and SHALL enter BUSY on that edge.
REQ-013 On the granting edge, SHALL load token with the granted bit rotated left by one, wrapping bit N-1 to bit 0.
REQ-014 SHALL keep token always one-hot; token SHALL change only on a granting edge.
REQ-015 In IDLE with req == 0, SHALL hold grant = 0, token and state unchanged.
REQ-016 In BUSY, SHALL hold grant unchanged while req of the granted requester stays high; requests from other requesters SHALL NOT change grant.
REQ-017 In BUSY, when req of the granted requester is sampled low, SHALL clear grant and return to IDLE on that edge, giving exactly one grant-free cycle before the next grant.
REQ-018 SHALL clear hold_cnt to 0 on every granting edge, increment it by 1 per BUSY cycle, saturate it at MAX_HOLD, and clear it to 0 on return to IDLE.
REQ-019 If a requester drops and re-raises req while IDLE, SHALL give it no priority beyond its position relative to token.
REQ-020 SHALL never assert more than one grant bit, and SHALL never grant a requester whose req was low at the granting edge.

Reset
REQ-021 When reset is sampled low, SHALL set state IDLE, grant 0, grant_valid 0, token = 1 (bit 0), and hold_cnt 0, regardless of the current state or req.
REQ-022 Reset asserted mid-grant SHALL take effect on that edge; the first grant after reset is released SHALL follow REQ-011 from token = 1.

Configuration
REQ-023 SHALL use macro ARB_TIMEOUT_EN to compile in tenure preemption.
REQ-024 With ARB_TIMEOUT_EN defined: in BUSY, when hold_cnt == MAX_HOLD-1 and any other req bit is high, SHALL clear grant and return to IDLE on that edge.
REQ-025 With ARB_TIMEOUT_EN defined and no other req bit high, SHALL keep the grant, with hold_cnt saturating at MAX_HOLD.
REQ-026 Without ARB_TIMEOUT_EN, SHALL never preempt, and SHALL tie hold_cnt to constant 0 with no counter logic.

Verification
REQ-027 Reset check: hold reset low 2 cycles with req=4'b1111 -> grant=0, token=4'b0001, hold_cnt=0; release reset -> grant=4'b0001 one cycle later, token=4'b0010.
REQ-028 Round-robin check: req=4'b1111, each grantee drops req one cycle after being granted and re-raises it in the following cycle -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-029 Wrap check: token=4'b1000 with req=4'b0011 -> grant=4'b0001 and token=4'b0010.
REQ-030 Hold check: req[2] alone high for 20 cycles -> grant=4'b0100 for all 20 cycles; raise req[0] mid-tenure -> grant unchanged without ARB_TIMEOUT_EN.
REQ-031 Preemption check (ARB_TIMEOUT_EN, MAX_HOLD=8): req[1] granted, req[3] raised at tenure cycle 2 -> grant drops at hold_cnt==7, then after one idle cycle grant=4'b1000.
REQ-032 Mid-operation reset: reset low during BUSY with grant=4'b0100 -> next edge grant=0, token=4'b0001, hold_cnt=0.
